count_scheduler: RTL and testbench
==================================

# count_scheduler

Round-robin scheduler that shares one small up-counter datapath (clock-driven counter with clear and enable) among N_REQ requesters. Each requester asks for a burst of `len` counts. The block grants the counter to one requester at a time, clears it, enables it for exactly `len` cycles, then signals completion. It sits between the requesting control blocks and the counter instance, and drives the counter's clear and enable controls.

## Interface
- N_REQ, 4, number of requesters (2..8)
- CNT_W, 3, counter and burst-length width in bits
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request level; held high until `done` or abort
- len  in  N_REQ*CNT_W  burst length per requester; requester i uses bits [i*CNT_W +: CNT_W]; sampled only at grant
- gnt  out  N_REQ  one-hot grant, all zero when idle
- cnt_clr  out  1  synchronous clear to the counter datapath
- cnt_en  out  1  count enable to the counter datapath
- cnt_val  out  CNT_W  mirror of the counter value for the current burst
- done  out  N_REQ  one-cycle completion pulse to the granted requester
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE. All outputs are registers or decoded from the state register only; there is no input-to-output combinational path.
- IDLE: if any `req` is high, pick the winner by round robin. Search starts at `ptr+1` and wraps modulo N_REQ. Latch the winner index `idx` and `len[idx]` into `blen`. Go to CLEAR.
- CLEAR: `gnt[idx]`=1, `cnt_clr`=1, `cnt_val`<=0. If `blen`==0, go to DONE; otherwise go to RUN.
- RUN: `gnt[idx]`=1, `cnt_en`=1, `cnt_val` increments each cycle. When `cnt_val`==`blen`-1 on the current cycle, go to DONE.
- DONE: `gnt[idx]`=1, `done[idx]`=1, `cnt_en`=0, `ptr`<=`idx`. Go to IDLE.
- Abort: if `req[idx]` is low in CLEAR or RUN, go to IDLE next cycle. On abort, `done` is not pulsed, `ptr`<=`idx`, and `cnt_val` holds its value.
- Arithmetic:
  - `cnt_val` never wraps, because `blen` ≤ 2^CNT_W-1. It ends each burst equal to `blen`.
  - `len` changes after grant are ignored.
- Round-robin fairness: a requester that keeps `req` high after `done` is served again only after every other pending requester has been served once.
- `ptr` reset value is N_REQ-1, so requester 0 wins first.

## Timing
- Reset: state=IDLE, gnt=0, cnt_clr=0, cnt_en=0, cnt_val=0, done=0, busy=0, ptr=N_REQ-1.
- Reset takes effect immediately, including mid-burst. All outputs drop asynchronously.
- For a request sampled high in IDLE at edge k:
  - CLEAR (gnt, cnt_clr, busy) is visible in cycle k+1.
  - `cnt_en` is high in cycles k+2 .. k+1+blen.
  - `done` is high in cycle k+2+blen.
  - IDLE is reached in cycle k+3+blen.
- Burst occupancy: blen+3 cycles. For blen=0 it is 3 cycles (IDLE, CLEAR, DONE), with no `cnt_en`.
- A new request can be granted at the earliest from IDLE, one cycle after DONE. Back-to-back bursts therefore have exactly one idle cycle between them.
- Simultaneous requests in IDLE: exactly one grant, chosen by rotating priority. Others wait with `req` held.
- `req` rising in the same cycle the FSM leaves DONE is seen in the following IDLE cycle.

## Structure
- Package `count_sched_pkg` holds:
  - the state encoding constants (IDLE=0, CLEAR=1, RUN=2, DONE=3) and the state width;
  - a function returning log2 of N_REQ, used for `idx`/`ptr` width.
- Sub-module `rr_pick`:
  - purely combinational rotating-priority picker;
  - inputs: `req`, `ptr`; outputs: `valid`, `idx`;
  - instantiated once in the top FSM.

## Test plan
- Reset mid-RUN (req[1]=1, len1=5, assert `rst` at the 3rd `cnt_en` cycle) -> all outputs 0 immediately; after release, requester 0 has priority.
- Single request req[0]=1, len0=3 -> gnt=4'b0001 for 5 cycles; `cnt_clr` 1 cycle; `cnt_en` 3 cycles; `cnt_val` sequence 0,1,2,3; done[0] pulse in cycle 5.
- All four requesting, each with len=2, held continuously -> grants in order 0,1,2,3,0. Each burst lasts 5 cycles, with 1 idle cycle between bursts.
- len2=0 with req[2]=1 -> gnt[2] for 2 cycles, `cnt_en` never high, done[2] pulses, `cnt_val` stays 0.
- Abort: req[3]=1, len3=7, drop req[3] after 2 `cnt_en` cycles -> IDLE next cycle, no done[3], `cnt_val`=2 held. The next grant goes to requester 0 if it is pending.
- Max length len0=7 with CNT_W=3 -> 7 `cnt_en` cycles, `cnt_val` ends at 7 with no wrap, done[0] in cycle 9.

Source files
------------

// File: rtl/count_sched_pkg.sv
// Shared definitions for the count scheduler: FSM state encoding and
// the index-width helper used for requester indices and the round-robin pointer.
package count_sched_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Ceiling log2 with a floor of 1 so that two requesters still get a 1-bit index.
  function automatic int idxWidth(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: searches from ptr+1 upward,
// wrapping modulo N_REQ, and reports the first requester found.
module rr_pick
  import count_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idxWidth(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % N_REQ);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/count_scheduler.sv
// Round-robin scheduler that lends one up-counter to N_REQ requesters,
// running a clear followed by exactly len enabled cycles per grant.
module count_scheduler
  import count_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*CNT_W-1:0] i_len,
  output logic [N_REQ-1:0]       o_gnt,
  output logic                   o_cnt_clr,
  output logic                   o_cnt_en,
  output logic [CNT_W-1:0]       o_cnt_val,
  output logic [N_REQ-1:0]       o_done,
  output logic                   o_busy
);

  localparam int IDX_W = idxWidth(N_REQ);

  state_t           r_state, w_nextState;
  logic [IDX_W-1:0] r_idx, r_ptr, w_pickIdx;
  logic             w_pickValid;
  logic [CNT_W-1:0] r_blen, r_cntVal, w_pickLen;
  logic             w_reqHeld, w_lastCount;
  logic [N_REQ-1:0] w_grantVec;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_valid (w_pickValid),
    .o_idx   (w_pickIdx)
  );

  assign w_reqHeld   = i_req[r_idx];
  assign w_lastCount = (r_cntVal == (r_blen - CNT_W'(1)));
  assign w_grantVec  = N_REQ'(1) << r_idx;
  assign o_cnt_val   = r_cntVal;

  always_comb begin
    w_pickLen = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == w_pickIdx) w_pickLen = i_len[i*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Outputs depend only on registered state and index; a dropped request wins over completion.
  always_comb begin
    w_nextState = r_state;
    o_gnt       = '0;
    o_cnt_clr   = 1'b0;
    o_cnt_en    = 1'b0;
    o_done      = '0;
    o_busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_pickValid) w_nextState = CLEAR;
      end
      CLEAR: begin
        o_gnt     = w_grantVec;
        o_cnt_clr = 1'b1;
        if (!w_reqHeld)        w_nextState = IDLE;
        else if (r_blen == '0) w_nextState = DONE;
        else                   w_nextState = RUN;
      end
      RUN: begin
        o_gnt    = w_grantVec;
        o_cnt_en = 1'b1;
        if (!w_reqHeld)       w_nextState = IDLE;
        else if (w_lastCount) w_nextState = DONE;
      end
      DONE: begin
        o_gnt       = w_grantVec;
        o_done      = w_grantVec;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // An abort leaves the count where it stopped but still advances the pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx    <= '0;
      r_ptr    <= IDX_W'(N_REQ - 1);
      r_blen   <= '0;
      r_cntVal <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pickValid) begin
            r_idx  <= w_pickIdx;
            r_blen <= w_pickLen;
          end
        end
        CLEAR: begin
          if (w_reqHeld) r_cntVal <= '0;
          else           r_ptr    <= r_idx;
        end
        RUN: begin
          if (w_reqHeld) r_cntVal <= r_cntVal + CNT_W'(1);
          else           r_ptr    <= r_idx;
        end
        DONE:    r_ptr <= r_idx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_count_scheduler.sv
// Directed bench for count_scheduler: cycle-by-cycle expected outputs
// for reset, single bursts, round robin, zero length, abort and maximum length.
module tb_count_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] len;
  logic [3:0]  gnt;
  logic        cntClr;
  logic        cntEn;
  logic [2:0]  cntVal;
  logic [3:0]  done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  count_scheduler #(.N_REQ(4), .CNT_W(3)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_len     (len),
    .o_gnt     (gnt),
    .o_cnt_clr (cntClr),
    .o_cnt_en  (cntEn),
    .o_cnt_val (cntVal),
    .o_done    (done),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic expectAll(input string tag, input logic [3:0] g, input logic clr, input logic en,
                           input logic [2:0] v, input logic [3:0] d, input logic b);
    checkOutput({tag, " gnt"},  32'(gnt),    32'(g));
    checkOutput({tag, " clr"},  32'(cntClr), 32'(clr));
    checkOutput({tag, " en"},   32'(cntEn),  32'(en));
    checkOutput({tag, " val"},  32'(cntVal), 32'(v));
    checkOutput({tag, " done"}, 32'(done),   32'(d));
    checkOutput({tag, " busy"}, 32'(busy),   32'(b));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [11:0] l);
    req = r;
    len = l;
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    req = '0;
    len = '0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    len = '0;
    #1 rst = 1'b1;
    #2 expectAll("reset", 4'b0000, 0, 0, 3'd0, 4'b0000, 0);
    nextCycle();
    #2 rst = 1'b0;

    // Reset during the third enabled cycle of requester 1's burst.
    applyStimulus(4'b0010, 12'h028);
    nextCycle(); expectAll("t1 clear", 4'b0010, 1, 0, 3'd0, 4'b0000, 1);
    nextCycle(); expectAll("t1 run0",  4'b0010, 0, 1, 3'd0, 4'b0000, 1);
    nextCycle(); expectAll("t1 run1",  4'b0010, 0, 1, 3'd1, 4'b0000, 1);
    nextCycle(); expectAll("t1 run2",  4'b0010, 0, 1, 3'd2, 4'b0000, 1);
    rst = 1'b1;
    #1 expectAll("t1 async", 4'b0000, 0, 0, 3'd0, 4'b0000, 0);
    #1 rst = 1'b0;
    applyStimulus(4'b0011, 12'h02B);
    nextCycle(); expectAll("t1 prio", 4'b0001, 1, 0, 3'd0, 4'b0000, 1);

    // Single request, len0=3.
    resetDut();
    applyStimulus(4'b0001, 12'h003);
    nextCycle(); expectAll("t2 clear", 4'b0001, 1, 0, 3'd0, 4'b0000, 1);
    nextCycle(); expectAll("t2 run0",  4'b0001, 0, 1, 3'd0, 4'b0000, 1);
    nextCycle(); expectAll("t2 run1",  4'b0001, 0, 1, 3'd1, 4'b0000, 1);
    nextCycle(); expectAll("t2 run2",  4'b0001, 0, 1, 3'd2, 4'b0000, 1);
    nextCycle(); expectAll("t2 done",  4'b0001, 0, 0, 3'd3, 4'b0001, 1);
    applyStimulus(4'b0000, 12'h003);
    nextCycle(); expectAll("t2 idle",  4'b0000, 0, 0, 3'd3, 4'b0000, 0);

    // Zero-length burst for requester 2.
    resetDut();
    applyStimulus(4'b0100, 12'h000);
    nextCycle(); expectAll("t3 clear", 4'b0100, 1, 0, 3'd0, 4'b0000, 1);
    nextCycle(); expectAll("t3 done",  4'b0100, 0, 0, 3'd0, 4'b0100, 1);
    applyStimulus(4'b0000, 12'h000);
    nextCycle(); expectAll("t3 idle",  4'b0000, 0, 0, 3'd0, 4'b0000, 0);

    // All four requesting with len=2: grants rotate 0,1,2,3,0.
    resetDut();
    applyStimulus(4'b1111, 12'h492);
    for (int b = 0; b < 5; b++) begin
      logic [3:0] g;
      logic [2:0] vPrev;
      g     = 4'b0001 << (b % 4);
      vPrev = (b == 0) ? 3'd0 : 3'd2;
      nextCycle(); expectAll($sformatf("t4 b%0d clear", b), g, 1, 0, vPrev, 4'b0000, 1);
      nextCycle(); expectAll($sformatf("t4 b%0d run0", b),  g, 0, 1, 3'd0,  4'b0000, 1);
      nextCycle(); expectAll($sformatf("t4 b%0d run1", b),  g, 0, 1, 3'd1,  4'b0000, 1);
      nextCycle(); expectAll($sformatf("t4 b%0d done", b),  g, 0, 0, 3'd2,  g,       1);
      if (b == 4) applyStimulus(4'b0000, 12'h492);
      nextCycle(); expectAll($sformatf("t4 b%0d idle", b),  4'b0000, 0, 0, 3'd2, 4'b0000, 0);
    end

    // Abort requester 3 (len3=7) once the count reaches 2; requester 0 is served next.
    resetDut();
    applyStimulus(4'b1000, 12'hE00);
    nextCycle(); expectAll("t5 clear", 4'b1000, 1, 0, 3'd0, 4'b0000, 1);
    nextCycle(); expectAll("t5 run0",  4'b1000, 0, 1, 3'd0, 4'b0000, 1);
    nextCycle(); expectAll("t5 run1",  4'b1000, 0, 1, 3'd1, 4'b0000, 1);
    nextCycle(); expectAll("t5 run2",  4'b1000, 0, 1, 3'd2, 4'b0000, 1);
    applyStimulus(4'b0001, 12'hE01);
    nextCycle(); expectAll("t5 abort", 4'b0000, 0, 0, 3'd2, 4'b0000, 0);
    nextCycle(); expectAll("t5 next",  4'b0001, 1, 0, 3'd2, 4'b0000, 1);
    nextCycle(); expectAll("t5 nrun",  4'b0001, 0, 1, 3'd0, 4'b0000, 1);
    nextCycle(); expectAll("t5 ndone", 4'b0001, 0, 0, 3'd1, 4'b0001, 1);
    applyStimulus(4'b0000, 12'h000);
    nextCycle(); expectAll("t5 idle",  4'b0000, 0, 0, 3'd1, 4'b0000, 0);

    // Maximum length len0=7: count ends at 7 without wrapping.
    resetDut();
    applyStimulus(4'b0001, 12'h007);
    nextCycle(); expectAll("t6 clear", 4'b0001, 1, 0, 3'd0, 4'b0000, 1);
    for (int v = 0; v < 7; v++) begin
      nextCycle(); expectAll($sformatf("t6 run%0d", v), 4'b0001, 0, 1, 3'(v), 4'b0000, 1);
    end
    nextCycle(); expectAll("t6 done", 4'b0001, 0, 0, 3'd7, 4'b0001, 1);
    applyStimulus(4'b0000, 12'h000);
    nextCycle(); expectAll("t6 idle", 4'b0000, 0, 0, 3'd7, 4'b0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
